// File: rtl/ov7670_capture_pkg.sv
// rtl/ov7670_capture_pkg.sv - shared types and constants for the OV7670 capture front-end
//
// Contents:
//   cap_state_t  capture FSM state (S_IDLE, S_ARMED, S_ACTIVE)
//   VGA_*/QVGA_* default active-window sizes
//   phase_width  bit width needed for the byte-phase counter
package ov7670_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2
    } cap_state_t;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int QVGA_H_ACTIVE = 320;
    localparam int QVGA_V_ACTIVE = 240;

    // A single-byte pixel still needs a 1-bit phase register so the
    // counter logic stays uniform across BYTES_PER_PIX values.
    function automatic int phase_width(input int bytes_per_pix);
        return (bytes_per_pix > 1) ? $clog2(bytes_per_pix) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - registered level with rise/fall pulses
//
// Ports:
//   clk   in   sampling clock
//   rst   in   synchronous active-high reset; register loads RESET_VAL
//   din   in   level to watch
//   rise  out  din = 1 while the register holds 0
//   fall  out  din = 0 while the register holds 1
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic level;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= RESET_VAL;
        end else begin
            level <= din;
        end
    end

    assign rise = din & ~level;
    assign fall = ~din & level;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 DVP pixel capture with frame/line tracking and 2:1 decimation
//
// Optional feature macro: CAPTURE_LINE_CHECK_EN (builds the sticky line-error checker).
//
// Ports:
//   PCLK           in   camera pixel clock (single clock)
//   RST            in   synchronous active-high reset
//   D              in   camera data byte
//   HREF           in   line-active qualifier
//   VSYNC          in   frame sync, high during vertical blanking
//   i_enable       in   arm capture
//   i_decimate     in   keep every 2nd pixel of every 2nd line (latched at frame start)
//   o_pixel        out  assembled pixel, first byte in the MSBs
//   o_valid        out  one-cycle write strobe for o_pixel/o_addr/o_col/o_row
//   o_addr         out  linear frame-buffer write address
//   o_col          out  column of the written pixel
//   o_row          out  row of the written pixel
//   o_frame_start  out  one-cycle pulse when a frame is entered
//   o_frame_done   out  one-cycle pulse when a frame ends on VSYNC rise
//   o_line_err     out  sticky line error (0 when the checker is not built)
module ov7670_pixel_capture
    import ov7670_capture_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = VGA_H_ACTIVE,
    parameter int V_ACTIVE      = VGA_V_ACTIVE,
    localparam int PIX_W        = DATA_W * BYTES_PER_PIX,
    localparam int ADDR_W       = $clog2(H_ACTIVE * V_ACTIVE),
    localparam int COL_OW       = $clog2(H_ACTIVE),
    localparam int ROW_OW       = $clog2(V_ACTIVE)
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] D,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic              i_enable,
    input  logic              i_decimate,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [COL_OW-1:0] o_col,
    output logic [ROW_OW-1:0] o_row,
    output logic              o_frame_start,
    output logic              o_frame_done,
    output logic              o_line_err
);

    // Internal counters are one step wider than the output fields so they
    // can sit at the limit (and the checker can count one past it).
    localparam int COL_CW = $clog2(H_ACTIVE + 2);
    localparam int ROW_CW = $clog2(V_ACTIVE + 1);
    localparam int PH_W   = phase_width(BYTES_PER_PIX);

    localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(BYTES_PER_PIX - 1);
    localparam logic [COL_CW-1:0] H_FULL    = COL_CW'(H_ACTIVE);
    localparam logic [COL_CW-1:0] H_HALF    = COL_CW'(H_ACTIVE / 2);
    localparam logic [ROW_CW-1:0] V_FULL    = ROW_CW'(V_ACTIVE);
    localparam logic [ROW_CW-1:0] V_HALF    = ROW_CW'(V_ACTIVE / 2);
    localparam logic [ADDR_W-1:0] STEP_FULL = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] STEP_HALF = ADDR_W'(H_ACTIVE / 2);

    cap_state_t        state;
    logic [PH_W-1:0]   phase;
    logic [PIX_W-1:0]  pix_sr;
    logic [COL_CW-1:0] col;
    logic [ROW_CW-1:0] row;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_base;
    logic              frame_dec;
    logic              raw_pix_odd;
    logic              raw_line_odd;
    logic              line_has_pix;

    logic href_rise, href_fall, vsync_rise, vsync_fall;

    sync_edge_det #(.RESET_VAL(1'b0)) u_href_edge (
        .clk  (PCLK),
        .rst  (RST),
        .din  (HREF),
        .rise (href_rise),
        .fall (href_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_vsync_edge (
        .clk  (PCLK),
        .rst  (RST),
        .din  (VSYNC),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    // Line starts are implied by the cleared line state, so HREF rise is not needed.
    logic unused_href_rise;
    assign unused_href_rise = href_rise;

    logic [PIX_W-1:0]  pix_next;
    logic [COL_CW-1:0] h_limit;
    logic [ROW_CW-1:0] v_limit;
    logic [ADDR_W-1:0] h_step;
    logic              frame_go;
    logic              pix_done;
    logic              keep_pix;
    logic              line_kept;
    logic              line_end;
    logic              wr_en;

    always_comb begin
        pix_next  = (pix_sr << DATA_W) | PIX_W'(D);
        h_limit   = frame_dec ? H_HALF : H_FULL;
        v_limit   = frame_dec ? V_HALF : V_FULL;
        h_step    = frame_dec ? STEP_HALF : STEP_FULL;
        frame_go  = (state == S_ARMED) && i_enable && vsync_fall;
        // A VSYNC rise ends the frame in the same cycle, so any pixel or line
        // completing on that edge is discarded.
        pix_done  = (state == S_ACTIVE) && HREF && (phase == LAST_PH) && !vsync_rise;
        line_end  = (state == S_ACTIVE) && href_fall && !vsync_rise;
        keep_pix  = !frame_dec || (!raw_pix_odd && !raw_line_odd);
        line_kept = !frame_dec || !raw_line_odd;
        wr_en     = pix_done && (col < h_limit) && (row < v_limit) && keep_pix;
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            state         <= S_IDLE;
            phase         <= '0;
            pix_sr        <= '0;
            col           <= '0;
            row           <= '0;
            addr          <= '0;
            row_base      <= '0;
            frame_dec     <= 1'b0;
            raw_pix_odd   <= 1'b0;
            raw_line_odd  <= 1'b0;
            line_has_pix  <= 1'b0;
            o_pixel       <= '0;
            o_valid       <= 1'b0;
            o_addr        <= '0;
            o_col         <= '0;
            o_row         <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else if (frame_go) begin
                        state         <= S_ACTIVE;
                        o_frame_start <= 1'b1;
                        frame_dec     <= i_decimate;
                        col           <= '0;
                        row           <= '0;
                        addr          <= '0;
                        row_base      <= '0;
                        raw_pix_odd   <= 1'b0;
                        raw_line_odd  <= 1'b0;
                        line_has_pix  <= 1'b0;
                        phase         <= '0;
                    end
                end

                S_ACTIVE: begin
                    // i_enable is only consulted here, so dropping it mid-frame
                    // lets the frame run to its VSYNC rise.
                    if (vsync_rise) begin
                        state        <= i_enable ? S_ARMED : S_IDLE;
                        o_frame_done <= 1'b1;
                        phase        <= '0;
                    end else if (HREF) begin
                        pix_sr <= pix_next;
                        if (phase == LAST_PH) begin
                            phase        <= '0;
                            line_has_pix <= 1'b1;
                            raw_pix_odd  <= ~raw_pix_odd;
                            if (wr_en) begin
                                o_valid <= 1'b1;
                                o_pixel <= pix_next;
                                o_addr  <= addr;
                                o_col   <= COL_OW'(col);
                                o_row   <= ROW_OW'(row);
                                col     <= col + 1'b1;
                                addr    <= addr + 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end else begin
                        // Any half-assembled pixel is abandoned here.
                        phase <= '0;
                        if (line_end) begin
                            col          <= '0;
                            raw_pix_odd  <= 1'b0;
                            line_has_pix <= 1'b0;
                            if (line_has_pix) begin
                                raw_line_odd <= ~raw_line_odd;
                                // Rows advance by a running base so a short line
                                // still leaves the next row at row*limit.
                                if (line_kept && (row < v_limit)) begin
                                    row      <= row + 1'b1;
                                    row_base <= row_base + h_step;
                                    addr     <= row_base + h_step;
                                end
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CAPTURE_LINE_CHECK_EN
    localparam logic [COL_CW-1:0] ELIG_MAX = COL_CW'(H_ACTIVE + 1);

    // Counts pixels at kept horizontal positions, ignoring the line limit,
    // so a too-long line is visible; saturates one past the full width.
    logic [COL_CW-1:0] elig_cnt;
    logic              line_err;
    logic              keep_pos;

    assign keep_pos = !frame_dec || !raw_pix_odd;

    always_ff @(posedge PCLK) begin
        if (RST) begin
            elig_cnt <= '0;
            line_err <= 1'b0;
        end else if (frame_go) begin
            elig_cnt <= '0;
            line_err <= 1'b0;
        end else begin
            if (pix_done && keep_pos && (elig_cnt != ELIG_MAX)) begin
                elig_cnt <= elig_cnt + 1'b1;
            end
            if (line_end) begin
                elig_cnt <= '0;
                if (phase != '0) begin
                    line_err <= 1'b1;
                end
                if (line_has_pix && ((elig_cnt != h_limit) || (line_kept && (row >= v_limit)))) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

    assign o_line_err = line_err;
`else
    assign o_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb/tb_ov7670_pixel_capture.sv - directed self-checking bench for ov7670_pixel_capture (8x4 window, RGB565)
module tb_ov7670_pixel_capture;

`ifdef CAPTURE_LINE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        PCLK;
    logic        RST;
    logic [7:0]  D;
    logic        HREF;
    logic        VSYNC;
    logic        i_enable;
    logic        i_decimate;
    logic [15:0] o_pixel;
    logic        o_valid;
    logic [4:0]  o_addr;
    logic [2:0]  o_col;
    logic [1:0]  o_row;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_line_err;

    ov7670_pixel_capture #(
        .DATA_W        (8),
        .BYTES_PER_PIX (2),
        .H_ACTIVE      (8),
        .V_ACTIVE      (4)
    ) dut (
        .PCLK          (PCLK),
        .RST           (RST),
        .D             (D),
        .HREF          (HREF),
        .VSYNC         (VSYNC),
        .i_enable      (i_enable),
        .i_decimate    (i_decimate),
        .o_pixel       (o_pixel),
        .o_valid       (o_valid),
        .o_addr        (o_addr),
        .o_col         (o_col),
        .o_row         (o_row),
        .o_frame_start (o_frame_start),
        .o_frame_done  (o_frame_done),
        .o_line_err    (o_line_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_pix[$];
    logic [4:0]  wr_addr[$];
    logic [2:0]  wr_col[$];
    logic [1:0]  wr_row[$];
    int          fs_cnt = 0;
    int          fd_cnt = 0;

    always @(negedge PCLK) begin
        if (o_valid) begin
            wr_pix.push_back(o_pixel);
            wr_addr.push_back(o_addr);
            wr_col.push_back(o_col);
            wr_row.push_back(o_row);
        end
        if (o_frame_start) fs_cnt++;
        if (o_frame_done)  fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Pixel p of line id is sent as bytes {id, p}.
    task automatic send_line(input int id, input int npix, input int nextra, input bit chk_lat);
        HREF = 1'b1;
        for (int p = 0; p < npix; p++) begin
            D = 8'(id);
            step();
            if (chk_lat && p == 1) chk("valid_one_cycle", o_valid, 0);
            D = 8'(p);
            step();
            if (chk_lat && p == 0) begin
                chk("valid_latency", o_valid, 1);
                chk("latency_pixel", o_pixel, {8'(id), 8'h00});
            end
        end
        for (int e = 0; e < nextra; e++) begin
            D = 8'hEE;
            step();
        end
        HREF = 1'b0;
        D    = 8'h00;
        repeat (3) step();
    endtask

    task automatic frame_begin(input logic exp_start);
        VSYNC = 1'b1;
        step();
        step();
        VSYNC = 1'b0;
        step();
        chk("frame_start_pulse", o_frame_start, exp_start);
        step();
    endtask

    task automatic frame_end(input logic exp_done);
        VSYNC = 1'b1;
        step();
        chk("frame_done_pulse", o_frame_done, exp_done);
        step();
    endtask

    int b;
    int f0;
    int d0;

    initial begin
        RST        = 1'b1;
        D          = 8'h00;
        HREF       = 1'b0;
        VSYNC      = 1'b0;
        i_enable   = 1'b1;
        i_decimate = 1'b0;
        repeat (3) step();

        chk("rst_valid", o_valid, 0);
        chk("rst_pixel", o_pixel, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_col", o_col, 0);
        chk("rst_row", o_row, 0);
        chk("rst_fstart", o_frame_start, 0);
        chk("rst_fdone", o_frame_done, 0);
        chk("rst_line_err", o_line_err, 0);

        // VSYNC already low at reset release: no capture until a full high->low
        RST = 1'b0;
        b = wr_pix.size();
        send_line(0, 8, 0, 0);
        send_line(1, 8, 0, 0);
        chk("no_wr_before_vsync", wr_pix.size() - b, 0);
        chk("no_start_before_vsync", fs_cnt, 0);

        // Full frame
        b = wr_pix.size(); f0 = fs_cnt; d0 = fd_cnt;
        frame_begin(1);
        send_line(0, 8, 0, 1);
        for (int l = 1; l < 4; l++) send_line(l, 8, 0, 0);
        frame_end(1);
        step();
        chk("full_count", wr_pix.size() - b, 32);
        for (int k = 0; k < 32; k++) begin
            chk("full_addr", wr_addr[b+k], k);
            chk("full_pix", wr_pix[b+k], {8'(k / 8), 8'(k % 8)});
            chk("full_col", wr_col[b+k], k % 8);
            chk("full_row", wr_row[b+k], k / 8);
        end
        chk("full_fstart_cnt", fs_cnt - f0, 1);
        chk("full_fdone_cnt", fd_cnt - d0, 1);
        chk("full_line_err", o_line_err, 0);

        // Decimated frame; mode latched at frame start
        b = wr_pix.size();
        i_decimate = 1'b1;
        frame_begin(1);
        i_decimate = 1'b0;
        for (int l = 0; l < 4; l++) send_line(l, 8, 0, 0);
        frame_end(1);
        step();
        chk("dec_count", wr_pix.size() - b, 8);
        for (int k = 0; k < 8; k++) begin
            chk("dec_addr", wr_addr[b+k], k);
            chk("dec_pix", wr_pix[b+k], {8'(2 * (k / 4)), 8'(2 * (k % 4))});
            chk("dec_col", wr_col[b+k], k % 4);
            chk("dec_row", wr_row[b+k], k / 4);
        end
        chk("dec_r1c0_pix", wr_pix[b+4], 16'h0200);
        chk("dec_last_addr", wr_addr[b+7], 7);
        chk("dec_line_err", o_line_err, 0);

        // Over-long first line: 9th pixel dropped
        b = wr_pix.size();
        frame_begin(1);
        send_line(0, 9, 0, 0);
        for (int l = 1; l < 4; l++) send_line(l, 8, 0, 0);
        frame_end(1);
        step();
        chk("long_count", wr_pix.size() - b, 32);
        chk("long_last_of_line0", wr_pix[b+7], 16'h0007);
        chk("long_first_of_line1", wr_pix[b+8], 16'h0100);
        chk("long_addr_line1", wr_addr[b+8], 8);
        chk("long_last_addr", wr_addr[b+31], 31);
        chk("long_line_err", o_line_err, ERR_EXP);

        // HREF falls after 3 bytes: one write, trailing byte discarded
        b = wr_pix.size();
        frame_begin(1);
        chk("err_cleared_at_start", o_line_err, 0);
        send_line(0, 1, 1, 0);
        send_line(1, 8, 0, 0);
        frame_end(1);
        step();
        chk("part_count", wr_pix.size() - b, 9);
        chk("part_pix0", wr_pix[b], 16'h0000);
        chk("part_addr0", wr_addr[b], 0);
        chk("part_next_pix", wr_pix[b+1], 16'h0100);
        chk("part_next_addr", wr_addr[b+1], 8);
        chk("part_next_row", wr_row[b+1], 1);
        chk("part_next_col", wr_col[b+1], 0);
        chk("part_last_pix", wr_pix[b+8], 16'h0107);
        chk("part_last_addr", wr_addr[b+8], 15);
        chk("part_line_err", o_line_err, ERR_EXP);

        // i_enable dropped mid-frame: frame completes, then idle
        b = wr_pix.size(); d0 = fd_cnt;
        frame_begin(1);
        send_line(0, 8, 0, 0);
        send_line(1, 8, 0, 0);
        i_enable = 1'b0;
        send_line(2, 8, 0, 0);
        send_line(3, 8, 0, 0);
        frame_end(1);
        step();
        chk("dis_count", wr_pix.size() - b, 32);
        chk("dis_last_addr", wr_addr[b+31], 31);
        chk("dis_fdone_cnt", fd_cnt - d0, 1);
        b = wr_pix.size(); f0 = fs_cnt;
        frame_begin(0);
        send_line(0, 8, 0, 0);
        frame_end(0);
        chk("idle_count", wr_pix.size() - b, 0);
        chk("idle_fstart_cnt", fs_cnt - f0, 0);
        i_enable = 1'b1;
        step();

        // Five lines: the fifth is beyond the frame limit
        b = wr_pix.size();
        frame_begin(1);
        for (int l = 0; l < 5; l++) send_line(l, 8, 0, 0);
        frame_end(1);
        step();
        chk("extra_line_count", wr_pix.size() - b, 32);
        chk("extra_line_last_addr", wr_addr[b+31], 31);
        chk("extra_line_last_pix", wr_pix[b+31], 16'h0307);
        chk("extra_line_err", o_line_err, ERR_EXP);

        // RST mid-frame: no frame_done afterwards
        b = wr_pix.size(); d0 = fd_cnt;
        frame_begin(1);
        send_line(0, 8, 0, 0);
        send_line(1, 8, 0, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_line_err", o_line_err, 0);
        frame_end(0);
        step();
        chk("midrst_count", wr_pix.size() - b, 16);
        chk("midrst_fdone_cnt", fd_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
